// File: rtl/pipe_controller_if.sv
// Control/hazard bundle between the ARM pipeline datapath and pipe_controller.
// master = controller side, slave = datapath side.
interface pipe_controller_if;
  logic [31:0] InstrD;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrcD;
  logic [1:0]  ImmSrcD;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic        BranchTakenE;
  logic        MemWriteM;
  logic        MemtoRegW;
  logic        RegWriteW;
  logic        PCSrcW;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;

  modport master (
    input  InstrD, ALUFlags,
    output RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemWriteM,
           MemtoRegW, RegWriteW, PCSrcW, StallF, StallD, FlushD, FlushE,
           ForwardAE, ForwardBE
  );

  modport slave (
    output InstrD, ALUFlags,
    input  RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemWriteM,
           MemtoRegW, RegWriteW, PCSrcW, StallF, StallD, FlushD, FlushE,
           ForwardAE, ForwardBE
  );
endinterface

// File: rtl/pipe_controller.sv
// Control and hazard unit for the 5-stage ARMv4-subset pipeline.
// Define PIPE_FORWARD_EN for M/W->E forwarding; otherwise RAW hazards stall in D.
module pipe_controller (
  input  logic              clk,
  input  logic              reset,
  pipe_controller_if.master bus
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011
  } alu_op_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       pc_src;
    logic [1:0] flag_write;   // {NZ, CV}
    logic       alu_src;
    alu_op_t    alu_ctl;
    logic [3:0] cond;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
  } ex_ctrl_t;

  ex_ctrl_t   d, e;
  logic [1:0] reg_src_d, imm_src_d;
  logic [1:0] op;
  logic [3:0] cmd, rn, rd, rm;
  logic       i_bit, s_bit;

  assign op    = bus.InstrD[27:26];
  assign i_bit = bus.InstrD[25];
  assign cmd   = bus.InstrD[24:21];
  assign s_bit = bus.InstrD[20];
  assign rn    = bus.InstrD[19:16];
  assign rd    = bus.InstrD[15:12];
  assign rm    = bus.InstrD[3:0];

  logic unused_bits;
  assign unused_bits = ^bus.InstrD[11:4];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    d         = '0;
    d.alu_ctl = ALU_ADD;
    reg_src_d = 2'b00;
    imm_src_d = 2'b00;
    case (op)
      2'b00: begin
        d.alu_src = i_bit;
        case (cmd)
          4'b0100: begin d.reg_write = 1'b1; d.alu_ctl = ALU_ADD; d.flag_write = {2{s_bit}}; end
          4'b0010: begin d.reg_write = 1'b1; d.alu_ctl = ALU_SUB; d.flag_write = {2{s_bit}}; end
          4'b0000: begin d.reg_write = 1'b1; d.alu_ctl = ALU_AND; d.flag_write = {s_bit, 1'b0}; end
          4'b1100: begin d.reg_write = 1'b1; d.alu_ctl = ALU_ORR; d.flag_write = {s_bit, 1'b0}; end
          4'b1010: begin d.alu_ctl = ALU_SUB; d.flag_write = 2'b11; end
          default: ;
        endcase
      end
      2'b01: begin
        d.alu_src = 1'b1;
        imm_src_d = 2'b01;
        if (s_bit) begin
          d.reg_write  = 1'b1;
          d.mem_to_reg = 1'b1;
        end else begin
          d.mem_write = 1'b1;
          reg_src_d   = 2'b10;
        end
      end
      2'b10: begin
        d.branch  = 1'b1;
        d.alu_src = 1'b1;
        imm_src_d = 2'b10;
        reg_src_d = 2'b01;
      end
      default: ;
    endcase
    d.pc_src = d.reg_write & (rd == 4'd15);
    d.cond   = bus.InstrD[31:28];
    d.ra1    = reg_src_d[0] ? 4'd15 : rn;
    d.ra2    = reg_src_d[1] ? rd : rm;
    d.wa3    = rd;
  end

  // Condition evaluation against the architectural flags held here, not the live ALU flags.
  logic [3:0] flags;
  logic       n, z, c, v, cond_ex;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (e.cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  logic branch_taken_e, data_stall, flush_e, pc_pend;
  assign branch_taken_e = e.branch & cond_ex;

  logic       reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m;
  logic [3:0] wa3_m;
  logic       reg_write_w, mem_to_reg_w, pc_src_w;
  logic [3:0] wa3_w;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush_e) e <= '0;
    else                  e <= d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 4'b0000;
    end else begin
      if (e.flag_write[1] && cond_ex) flags[3:2] <= bus.ALUFlags[3:2];
      if (e.flag_write[0] && cond_ex) flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      pc_src_m     <= 1'b0;
      wa3_m        <= 4'd0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      pc_src_w     <= 1'b0;
      wa3_w        <= 4'd0;
    end else begin
      reg_write_m  <= e.reg_write & cond_ex;
      mem_write_m  <= e.mem_write & cond_ex;
      mem_to_reg_m <= e.mem_to_reg;
      pc_src_m     <= e.pc_src & cond_ex;
      wa3_m        <= e.wa3;
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
      pc_src_w     <= pc_src_m;
      wa3_w        <= wa3_m;
    end
  end

  logic hit_e, hit_m;
  assign hit_e = (e.wa3 == d.ra1) | (e.wa3 == d.ra2);
  assign hit_m = (wa3_m == d.ra1) | (wa3_m == d.ra2);

`ifdef PIPE_FORWARD_EN
  logic unused_hit;
  assign unused_hit = hit_m;
  assign data_stall = e.mem_to_reg & hit_e;

  always_comb begin
    bus.ForwardAE = 2'b00;
    bus.ForwardBE = 2'b00;
    if (reg_write_m && wa3_m == e.ra1)      bus.ForwardAE = 2'b10;
    else if (reg_write_w && wa3_w == e.ra1) bus.ForwardAE = 2'b01;
    if (reg_write_m && wa3_m == e.ra2)      bus.ForwardBE = 2'b10;
    else if (reg_write_w && wa3_w == e.ra2) bus.ForwardBE = 2'b01;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{e.ra1, e.ra2, wa3_w};
  assign data_stall = (e.reg_write & hit_e) | (reg_write_m & hit_m);
  assign bus.ForwardAE = 2'b00;
  assign bus.ForwardBE = 2'b00;
`endif

  assign pc_pend = d.pc_src | e.pc_src | pc_src_m;
  assign flush_e = data_stall | branch_taken_e;

  assign bus.RegSrcD      = reg_src_d;
  assign bus.ImmSrcD      = imm_src_d;
  assign bus.ALUSrcE      = e.alu_src;
  assign bus.ALUControlE  = e.alu_ctl;
  assign bus.BranchTakenE = branch_taken_e;
  assign bus.MemWriteM    = mem_write_m;
  assign bus.MemtoRegW    = mem_to_reg_w;
  assign bus.RegWriteW    = reg_write_w;
  assign bus.PCSrcW       = pc_src_w;
  assign bus.StallF       = data_stall | pc_pend;
  assign bus.StallD       = data_stall;
  assign bus.FlushD       = pc_pend | pc_src_w | branch_taken_e;
  assign bus.FlushE       = flush_e;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: drives InstrD/ALUFlags cycle by cycle as the datapath would.
// Expectations cover both builds, selected by PIPE_FORWARD_EN.
module tb_pipe_controller;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pipe_controller_if bus ();

  pipe_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP     = 32'hEC00_0000; // op=11: no writes
  localparam logic [31:0] ADD123  = 32'hE082_1003; // ADD R1,R2,R3
  localparam logic [31:0] SUB415  = 32'hE041_4005; // SUB R4,R1,R5
  localparam logic [31:0] LDR10   = 32'hE590_1000; // LDR R1,[R0]
  localparam logic [31:0] ADD211  = 32'hE081_2001; // ADD R2,R1,R1
  localparam logic [31:0] CMP00   = 32'hE150_0000; // CMP R0,R0
  localparam logic [31:0] BEQ     = 32'h0A00_0000; // BEQ
  localparam logic [31:0] ADDSNE  = 32'h1092_1003; // ADDSNE R1,R2,R3
  localparam logic [31:0] ADDPC   = 32'hE280_F000; // ADD R15,R0,#0
  localparam logic [31:0] ADD234  = 32'hE083_2004; // ADD R2,R3,R4
  localparam logic [31:0] STR10   = 32'hE580_1000; // STR R1,[R0]

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are examined on the following negedge.
  task automatic cyc(input logic [31:0] instr, input logic [3:0] flags, input logic rst);
    @(posedge clk);
    #1;
    bus.InstrD   = instr;
    bus.ALUFlags = flags;
    reset        = rst;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(NOP, 4'h0, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.InstrD   = NOP;
    bus.ALUFlags = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_regwritew", bus.RegWriteW, 0);
    check("rst_memwritem", bus.MemWriteM, 0);
    check("rst_pcsrcw", bus.PCSrcW, 0);
    check("rst_branchtaken", bus.BranchTakenE, 0);
    check("rst_flushe", bus.FlushE, 0);
    check("rst_fwd", {bus.ForwardAE, bus.ForwardBE}, 0);
    cyc(NOP, 4'h0, 1'b0);
    drain(2);

    // ADD R1 then SUB using R1
`ifdef PIPE_FORWARD_EN
    cyc(ADD123, 4'h0, 1'b0);
    check("a_stallf_t0", bus.StallF, 0);
    cyc(SUB415, 4'h0, 1'b0);
    check("a_stalld_t1", bus.StallD, 0);
    cyc(NOP, 4'h0, 1'b0);
    check("a_fwda", bus.ForwardAE, 2'b10);
    check("a_fwdb", bus.ForwardBE, 2'b00);
    check("a_aluctl_sub", bus.ALUControlE, 3'b001);
    cyc(NOP, 4'h0, 1'b0);
    check("a_regwritew", bus.RegWriteW, 1);
`else
    cyc(ADD123, 4'h0, 1'b0);
    check("a_stallf_t0", bus.StallF, 0);
    cyc(SUB415, 4'h0, 1'b0);
    check("a_stalld_t1", bus.StallD, 1);
    check("a_flushe_t1", bus.FlushE, 1);
    cyc(SUB415, 4'h0, 1'b0);
    check("a_stalld_t2", bus.StallD, 1);
    cyc(SUB415, 4'h0, 1'b0);
    check("a_stalld_t3", bus.StallD, 0);
    check("a_regwritew", bus.RegWriteW, 1);
    cyc(NOP, 4'h0, 1'b0);
    check("a_fwda", bus.ForwardAE, 2'b00);
    check("a_aluctl_sub", bus.ALUControlE, 3'b001);
`endif
    drain(4);

    // LDR R1 then dependent ADD
    cyc(LDR10, 4'h0, 1'b0);
    cyc(ADD211, 4'h0, 1'b0);
    check("b_stallf", bus.StallF, 1);
    check("b_stalld", bus.StallD, 1);
    check("b_flushe", bus.FlushE, 1);
`ifdef PIPE_FORWARD_EN
    cyc(ADD211, 4'h0, 1'b0);
    check("b_stalld_t2", bus.StallD, 0);
    cyc(NOP, 4'h0, 1'b0);
    check("b_memtoregw", bus.MemtoRegW, 1);
    check("b_fwda", bus.ForwardAE, 2'b01);
    check("b_fwdb", bus.ForwardBE, 2'b01);
`else
    cyc(ADD211, 4'h0, 1'b0);
    check("b_stalld_t2", bus.StallD, 1);
    cyc(ADD211, 4'h0, 1'b0);
    check("b_stalld_t3", bus.StallD, 0);
    check("b_memtoregw", bus.MemtoRegW, 1);
    cyc(NOP, 4'h0, 1'b0);
    check("b_fwda", bus.ForwardAE, 2'b00);
`endif
    drain(4);

    // BEQ with Z=0 not taken; CMP R0,R0 sets Z, then BEQ taken
    cyc(BEQ, 4'h0, 1'b0);
    check("c_regsrc_b", bus.RegSrcD, 2'b01);
    check("c_immsrc_b", bus.ImmSrcD, 2'b10);
    cyc(NOP, 4'h0, 1'b0);
    check("c_beq_nz", bus.BranchTakenE, 0);
    check("c_alusrc_b", bus.ALUSrcE, 1);
    cyc(CMP00, 4'h0, 1'b0);
    cyc(BEQ, 4'b0100, 1'b0);
    cyc(NOP, 4'h0, 1'b0);
    check("c_beq_taken", bus.BranchTakenE, 1);
    check("c_flushd", bus.FlushD, 1);
    check("c_flushe", bus.FlushE, 1);
    cyc(NOP, 4'h0, 1'b0);
    check("c_taken_once", bus.BranchTakenE, 0);
    check("c_flushe_once", bus.FlushE, 0);
    drain(3);

    // ADDSNE with Z=1: no reg write, flags untouched (BEQ still taken)
    cyc(ADDSNE, 4'h0, 1'b0);
    cyc(NOP, 4'h0, 1'b0);
    cyc(BEQ, 4'h0, 1'b0);
    cyc(NOP, 4'h0, 1'b0);
    check("d_regwritew_ne", bus.RegWriteW, 0);
    check("d_flags_kept", bus.BranchTakenE, 1);
    drain(3);

    // Write to R15
    cyc(ADDPC, 4'h0, 1'b0);
    check("e_stallf_t0", bus.StallF, 1);
    check("e_flushd_t0", bus.FlushD, 1);
    check("e_stalld_t0", bus.StallD, 0);
    cyc(NOP, 4'h0, 1'b0);
    cyc(NOP, 4'h0, 1'b0);
    check("e_stallf_t2", bus.StallF, 1);
    check("e_pcsrcw_t2", bus.PCSrcW, 0);
    cyc(NOP, 4'h0, 1'b0);
    check("e_pcsrcw_t3", bus.PCSrcW, 1);
    check("e_stallf_t3", bus.StallF, 0);
    check("e_flushd_t3", bus.FlushD, 1);
    cyc(NOP, 4'h0, 1'b0);
    check("e_flushd_t4", bus.FlushD, 0);
    drain(2);

    // Reset while STR is in M and ADD in W (flags still Z=1 here)
    cyc(ADD234, 4'h0, 1'b0);
    cyc(STR10, 4'h0, 1'b0);
    check("f_regsrc_str", bus.RegSrcD, 2'b10);
    check("f_immsrc_str", bus.ImmSrcD, 2'b01);
    cyc(NOP, 4'h0, 1'b0);
    cyc(NOP, 4'h0, 1'b1);
    check("f_memwritem_pre", bus.MemWriteM, 1);
    check("f_regwritew_pre", bus.RegWriteW, 1);
    cyc(NOP, 4'h0, 1'b0);
    check("f_memwritem_rst", bus.MemWriteM, 0);
    check("f_regwritew_rst", bus.RegWriteW, 0);
    cyc(BEQ, 4'h0, 1'b0);
    cyc(NOP, 4'h0, 1'b0);
    check("f_flags_cleared", bus.BranchTakenE, 0);
    drain(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
